unary_bsg_array: RTL and testbench

- Downstream consumer of the shared Sobol RNG array.
- Accepts one vector of NUM binary operands per transaction over a valid/ready handshake.
- For a programmable number of cycles, compares each operand against its lane's shared RNG value and emits one unary bitstream bit per lane per cycle.
- Drives the RNG array's enable, so the RNG advances only while bits are being generated. Feeds the uBrain unary compute lanes.

---
 rtl/unary_bsg_array.sv | 126 ++++++++++++
 tb/tb_unary_bsg_array.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/unary_bsg_array.sv
// Unary bitstream generator array.
// Accepts one vector of NUM unsigned operands per transaction. For run_len cycles it compares
// each operand against its lane's shared RNG value and emits one unary bit per lane per cycle.
// The RNG array is enabled only while a bit is actually being produced, so back-pressure
// freezes the RNG and no values are skipped.
//
// Ports:
//   clk, rst    clock, asynchronous active-high reset
//   in_valid    operand vector valid
//   in_ready    block can accept an operand vector (IDLE)
//   in_data     NUM x RWID operands, lane i at [i*RWID +: RWID]
//   run_len     stream length in cycles, sampled with in_data
//   rng_in      NUM x RWID per-lane RNG values
//   rng_en      advance enable to the RNG array
//   out_stall   downstream back-pressure
//   bs_out      unary bit per lane (registered)
//   bs_valid    bs_out holds a new bit
//   done        one-cycle pulse, coincident with the final bit
module unary_bsg_array #(
  parameter int unsigned RWID = 10,
  parameter int unsigned NUM  = 32,
  parameter int unsigned LWID = RWID + 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [NUM*RWID-1:0] in_data,
  input  logic [LWID-1:0]     run_len,
  input  logic [NUM*RWID-1:0] rng_in,
  output logic                rng_en,
  input  logic                out_stall,
  output logic [NUM-1:0]      bs_out,
  output logic                bs_valid,
  output logic                done
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e              state_q, state_d;
  logic [NUM*RWID-1:0] src_q;
  logic [LWID-1:0]     cnt_q;
  logic [NUM-1:0]      bs_out_q;
  logic                bs_valid_q;
  logic [NUM-1:0]      cmp;
  logic                step;

  // Per-lane strict unsigned compare; 2^RWID-1 is the largest representable value, so 1.0
  // can never be encoded.
  always_comb begin
    cmp = '0;
    for (int unsigned i = 0; i < NUM; i++) begin
      cmp[i] = src_q[i*RWID +: RWID] > rng_in[i*RWID +: RWID];
    end
  end

  // A bit is produced on every unstalled RUN cycle.
  assign step = (state_q == StRun) && !out_stall;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (in_valid) begin
          state_d = (run_len == '0) ? StDone : StRun;
        end
      end
      StRun: begin
        if (step && (cnt_q == LWID'(1))) begin
          state_d = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs
  always_comb begin
    in_ready = (state_q == StIdle);
    rng_en   = step;
    done     = (state_q == StDone);
    bs_out   = bs_out_q;
    bs_valid = bs_valid_q;
  end

  // Datapath: operand capture, remaining-bit counter and registered bitstream.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      src_q      <= '0;
      cnt_q      <= '0;
      bs_out_q   <= '0;
      bs_valid_q <= 1'b0;
    end else begin
      // bs_valid is a one-cycle flag for each freshly produced bit; bs_out holds otherwise.
      bs_valid_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (in_valid) begin
            src_q <= in_data;
            cnt_q <= run_len;
          end
        end
        StRun: begin
          if (step) begin
            bs_out_q   <= cmp;
            bs_valid_q <= 1'b1;
            cnt_q      <= cnt_q - LWID'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_unary_bsg_array.sv
// Self-checking bench for unary_bsg_array (NUM=4, RWID=4).
// A sequence-based RNG stand-in advances only when rng_en is seen high, so the k-th valid bit
// of a lane must equal (src > seq[lane][k]).
module tb_unary_bsg_array;

  localparam int RW = 4;
  localparam int N  = 4;
  localparam int LW = RW + 1;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid;
  logic            in_ready;
  logic [N*RW-1:0] in_data;
  logic [LW-1:0]   run_len;
  logic [N*RW-1:0] rng_in;
  logic            rng_en;
  logic            out_stall;
  logic [N-1:0]    bs_out;
  logic            bs_valid;
  logic            done;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [RW-1:0] seq   [N][40];
  logic [RW-1:0] src_v [N];
  int            rng_idx;

  unary_bsg_array #(
    .RWID(RW),
    .NUM (N),
    .LWID(LW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .run_len  (run_len),
    .rng_in   (rng_in),
    .rng_en   (rng_en),
    .out_stall(out_stall),
    .bs_out   (bs_out),
    .bs_valid (bs_valid),
    .done     (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_rng();
    for (int i = 0; i < N; i++) rng_in[i*RW +: RW] = seq[i][rng_idx];
  endtask

  // Called part-way through an IDLE cycle (after its falling edge).
  // stall_mode: 0 none, 1 fixed window [stall_at, stall_at+stall_len), 2 random.
  // abort_at >= 0 asserts reset once that many bits should be visible.
  task automatic run_txn(input int len, input int stall_mode, input int stall_at,
                         input int stall_len, input bit hold, input int abort_at);
    int            model_bits;
    int            valid_cnt;
    int            done_c;
    int            ones     [N];
    int            exp_ones [N];
    logic [N-1:0]  exp_out;
    bit            exp_valid;
    bit            exp_done;
    bit            en_s;
    bit            seen_done;
    model_bits = 0;
    valid_cnt  = 0;
    done_c     = -1;
    exp_out    = '0;
    seen_done  = 1'b0;
    for (int i = 0; i < N; i++) begin
      ones[i]     = 0;
      exp_ones[i] = 0;
      for (int k = 0; k < len; k++) if (src_v[i] > seq[i][k]) exp_ones[i]++;
    end
    rng_idx = 0;
    drive_rng();
    for (int i = 0; i < N; i++) in_data[i*RW +: RW] = src_v[i];
    run_len  = LW'(len);
    in_valid = 1'b1;
    chk("ready_idle", in_ready, 1);
    @(posedge clk);
    #1;
    in_valid  = hold;
    if (hold) in_data = N*RW'($urandom);
    out_stall = (stall_mode == 1 && stall_at == 0) ||
                (stall_mode == 2 && $urandom_range(0, 3) == 0);
    exp_valid = 1'b0;
    exp_done  = (len == 0);
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      chk("ready_busy", in_ready, 0);
      chk("done", done, exp_done);
      chk("bs_valid", bs_valid, exp_valid);
      chk("rng_en", rng_en, (model_bits < len) && !out_stall);
      if (exp_valid) chk("bs_out", bs_out, exp_out);
      if (bs_valid) begin
        valid_cnt++;
        for (int i = 0; i < N; i++) if (bs_out[i]) ones[i]++;
      end
      en_s = rng_en;
      if (exp_done || done) begin
        seen_done = 1'b1;
        done_c    = c;
        break;
      end
      if (model_bits < len && !out_stall) begin
        for (int i = 0; i < N; i++) exp_out[i] = src_v[i] > seq[i][model_bits];
        model_bits++;
        exp_valid = 1'b1;
        exp_done  = (model_bits == len);
      end else begin
        exp_valid = 1'b0;
        exp_done  = 1'b0;
      end
      @(posedge clk);
      #1;
      if (en_s) begin
        rng_idx++;
        drive_rng();
      end
      if (abort_at >= 0 && c + 1 == abort_at) begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_stall = 1'b0;
        #1;
        chk("abort_bs_valid", bs_valid, 0);
        chk("abort_bs_out", bs_out, 0);
        chk("abort_done", done, 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("abort_ready", in_ready, 1);
        return;
      end
      case (stall_mode)
        1:       out_stall = (c + 1 >= stall_at) && (c + 1 < stall_at + stall_len);
        2:       out_stall = ($urandom_range(0, 3) == 0);
        default: out_stall = 1'b0;
      endcase
      if (hold) in_data = N*RW'($urandom);
    end
    chk("done_seen", seen_done, 1);
    if (stall_mode == 0) chk("done_cycle", done_c, len);
    if (stall_mode == 1 && stall_at < len) chk("done_cycle_stall", done_c, len + stall_len);
    chk("valid_count", valid_cnt, len);
    for (int i = 0; i < N; i++) chk($sformatf("ones_lane%0d", i), ones[i], exp_ones[i]);
    @(posedge clk);
    #1;
    out_stall = 1'b0;
    @(negedge clk);
    chk("post_ready", in_ready, 1);
    chk("post_bs_valid", bs_valid, 0);
    chk("post_done", done, 0);
  endtask

  task automatic set_sweep();
    for (int i = 0; i < N; i++)
      for (int k = 0; k < 40; k++) seq[i][k] = RW'(k);
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_stall = 1'b0;
    in_data   = '0;
    run_len   = '0;
    rng_idx   = 0;
    for (int i = 0; i < N; i++) begin
      src_v[i] = '0;
      for (int k = 0; k < 40; k++) seq[i][k] = '0;
    end
    drive_rng();
    #2;
    chk("rst_ready", in_ready, 1);
    chk("rst_bs_valid", bs_valid, 0);
    chk("rst_bs_out", bs_out, 0);
    chk("rst_done", done, 0);
    chk("rst_rng_en", rng_en, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Full sweep: ones per lane equal the operand.
    set_sweep();
    src_v[0] = 4'd0; src_v[1] = 4'd5; src_v[2] = 4'd8; src_v[3] = 4'd15;
    run_txn(16, 0, 0, 0, 1'b0, -1);

    // Same run with a 3-cycle stall at bit 6.
    run_txn(16, 1, 6, 3, 1'b0, -1);

    // Zero-length run.
    for (int i = 0; i < N; i++) src_v[i] = 4'd8;
    run_txn(0, 0, 0, 0, 1'b0, -1);

    // in_valid held high with in_data churning during the run, then a second vector.
    src_v[0] = 4'd3; src_v[1] = 4'd12; src_v[2] = 4'd7; src_v[3] = 4'd1;
    run_txn(16, 0, 0, 0, 1'b1, -1);
    src_v[0] = 4'd9; src_v[1] = 4'd2; src_v[2] = 4'd14; src_v[3] = 4'd6;
    run_txn(16, 0, 0, 0, 1'b0, -1);
    in_valid = 1'b0;

    // Reset mid-run, then a clean run.
    src_v[0] = 4'd0; src_v[1] = 4'd5; src_v[2] = 4'd8; src_v[3] = 4'd15;
    run_txn(16, 0, 0, 0, 1'b0, 7);
    run_txn(16, 0, 0, 0, 1'b0, -1);

    // Single-bit run: src 3 against rng 2.
    for (int i = 0; i < N; i++) begin
      src_v[i]  = 4'd3;
      seq[i][0] = 4'd2;
    end
    run_txn(1, 0, 0, 0, 1'b0, -1);

    // Randomized runs with random back-pressure.
    for (int t = 0; t < 8; t++) begin
      for (int i = 0; i < N; i++) begin
        src_v[i] = RW'($urandom);
        for (int k = 0; k < 40; k++) seq[i][k] = RW'($urandom);
      end
      run_txn(int'($urandom_range(1, 24)), 2, 0, 0, 1'($urandom_range(0, 1)), -1);
      in_valid = 1'b0;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
